xnpc_shadow_ctrl: RTL and testbench

XNPC_SHADOW_CTRL -- requirements
Module: xnpc_shadow_ctrl

---
 rtl/xnpc_shadow_ctrl.sv | 161 ++++++++++++++++
 tb/tb_xnpc_shadow_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xnpc_shadow_ctrl.sv
// xnpc_shadow_ctrl
//
// Double-buffered (shadow) configuration control for the decoder datapath.
// The AXI4-Lite slave owns the "shadow" register values. Software writes
// them at any time, then issues a commit. The new values are copied into
// the active set only at the next carrier-period boundary (sync_i). The
// decoder therefore never sees a half-updated configuration in mid-period.
//
// Optional feature (macro XNPC_SHADOW_TIMEOUT_EN):
//   When defined, a pending commit that sees no sync_i for TIMEOUT_CYCLES
//   cycles is force-loaded and the sticky timeout_o flag is raised.
//   When undefined, no counter exists, timeout_o is tied low, and clr_i
//   is ignored.
//
// Ports:
//   ACLK        clock, all logic on the rising edge
//   ARESETN     asynchronous active-low reset
//   reg_wr_i    per-register write strobe from the AXI slave
//   reg_data_i  AXI-side register values, register k at [k*DATA_WIDTH +: DATA_WIDTH]
//   commit_i    software apply request
//   sync_i      carrier-period boundary
//   clr_i       clears timeout_o
//   active_o    configuration applied to the decoder
//   dirty_o     registers written but not yet applied
//   pending_o   commit accepted, waiting for sync_i
//   update_o    one-cycle pulse the cycle after active_o was loaded
//   timeout_o   sticky forced-load flag
module xnpc_shadow_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [NUM_REGS-1:0]            reg_wr_i,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_data_i,
    input  logic                           commit_i,
    input  logic                           sync_i,
    input  logic                           clr_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] active_o,
    output logic [NUM_REGS-1:0]            dirty_o,
    output logic                           pending_o,
    output logic                           update_o,
    output logic                           timeout_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t                         state;
    state_t                         state_next;
    logic                           load;
    logic                           forced;
    logic [NUM_REGS-1:0]            load_mask;
    logic [NUM_REGS-1:0]            clear_mask;
    logic [NUM_REGS*DATA_WIDTH-1:0] active_q;
    logic [NUM_REGS-1:0]            dirty_q;
    logic                           update_q;

    // A register written in the load cycle itself is loaded from that
    // cycle's data but keeps its dirty bit. The write strobe lands on the
    // same edge, so the value is marked as still to be applied again.
    assign load_mask  = dirty_q | reg_wr_i;
    assign clear_mask = load ? load_mask : '0;

    // Next-state logic. A commit with nothing dirty is dropped. A commit
    // seen while already PENDING is ignored, so the timeout is never restarted.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (commit_i && (dirty_q != '0)) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (sync_i || forced) begin
                    load       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Only the slices in the load mask are copied. Every other slice of the
    // active set holds its value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            active_q <= '0;
            dirty_q  <= '0;
            update_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (load && load_mask[k]) begin
                    active_q[k*DATA_WIDTH +: DATA_WIDTH] <= reg_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            dirty_q  <= (dirty_q & ~clear_mask) | reg_wr_i;
            update_q <= load;
        end
    end

`ifdef XNPC_SHADOW_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    // The forced load fires on the edge that ends the TIMEOUT_CYCLES-th
    // PENDING cycle. It applies only when no real sync arrives at that edge.
    assign forced = (state == PENDING) && (cnt_q == CNT_LAST) && !sync_i;

    // The counter restarts on PENDING entry. A new timeout takes priority
    // over clr_i, so a coincident clear cannot lose the event.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == IDLE && state_next == PENDING) begin
                cnt_q <= '0;
            end else if (state == PENDING) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (forced) begin
                timeout_q <= 1'b1;
            end else if (clr_i) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_clr;

    assign unused_clr = clr_i;
    assign forced     = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    assign active_o  = active_q;
    assign dirty_o   = dirty_q;
    assign pending_o = (state == PENDING);
    assign update_o  = update_q;

endmodule

// File: tb/tb_xnpc_shadow_ctrl.sv
// tb_xnpc_shadow_ctrl
//
// Bench for xnpc_shadow_ctrl with DATA_WIDTH=32 and NUM_REGS=4.
// Each record in the vector table holds the inputs for one cycle and the
// outputs expected just after that cycle's rising edge. Expected records
// go into a queue when the stimulus is driven. They are popped and compared
// #1 after the edge. Reset behaviour is exercised in hand-written sequences.
// With XNPC_SHADOW_TIMEOUT_EN defined, the DUT is built with TIMEOUT_CYCLES=16.
module tb_xnpc_shadow_ctrl;

`ifdef XNPC_SHADOW_TIMEOUT_EN
    localparam int TO_CYC = 16;
    localparam int GAP    = 10;
`else
    localparam int TO_CYC = 1024;
    localparam int GAP    = 20;
`endif

    typedef struct {
        logic [3:0]   wr;
        logic [127:0] data;
        logic         commit;
        logic         sync;
        logic         clr;
        logic [127:0] e_act;
        logic [3:0]   e_dirty;
        logic         e_pend;
        logic         e_upd;
        logic         e_to;
    } vec_t;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic [3:0]   reg_wr_i = '0;
    logic [127:0] reg_data_i = '0;
    logic         commit_i = 1'b0;
    logic         sync_i = 1'b0;
    logic         clr_i = 1'b0;
    logic [127:0] active_o;
    logic [3:0]   dirty_o;
    logic         pending_o;
    logic         update_o;
    logic         timeout_o;

    vec_t table_q[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    xnpc_shadow_ctrl #(
        .DATA_WIDTH    (32),
        .NUM_REGS      (4),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .reg_wr_i  (reg_wr_i),
        .reg_data_i(reg_data_i),
        .commit_i  (commit_i),
        .sync_i    (sync_i),
        .clr_i     (clr_i),
        .active_o  (active_o),
        .dirty_o   (dirty_o),
        .pending_o (pending_o),
        .update_o  (update_o),
        .timeout_o (timeout_o)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [127:0] sl(input int k, input logic [31:0] v);
        logic [127:0] w;
        w  = 128'(v);
        sl = w << (32 * k);
    endfunction

    function automatic vec_t mk(input logic [3:0] wr, input logic [127:0] data,
                                input logic c, input logic s, input logic cl,
                                input logic [127:0] ea, input logic [3:0] ed,
                                input logic ep, input logic eu, input logic et);
        vec_t v;
        v.wr = wr; v.data = data; v.commit = c; v.sync = s; v.clr = cl;
        v.e_act = ea; v.e_dirty = ed; v.e_pend = ep; v.e_upd = eu; v.e_to = et;
        return v;
    endfunction

    task automatic addVec(input logic [3:0] wr, input logic [127:0] data,
                          input logic c, input logic s, input logic cl,
                          input logic [127:0] ea, input logic [3:0] ed,
                          input logic ep, input logic eu, input logic et);
        table_q.push_back(mk(wr, data, c, s, cl, ea, ed, ep, eu, et));
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic checkOutput();
        vec_t e;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL scoreboard: got empty queue, want an entry");
            n_mis++;
            return;
        end
        e = exp_q.pop_front();
        n_vec++;
        if (active_o !== e.e_act) begin
            $display("[TB] FAIL vec%0d active_o: got %h want %h", n_vec, active_o, e.e_act);
            n_mis++;
        end
        if (dirty_o !== e.e_dirty) begin
            $display("[TB] FAIL vec%0d dirty_o: got %b want %b", n_vec, dirty_o, e.e_dirty);
            n_mis++;
        end
        if (pending_o !== e.e_pend) begin
            $display("[TB] FAIL vec%0d pending_o: got %b want %b", n_vec, pending_o, e.e_pend);
            n_mis++;
        end
        if (update_o !== e.e_upd) begin
            $display("[TB] FAIL vec%0d update_o: got %b want %b", n_vec, update_o, e.e_upd);
            n_mis++;
        end
        if (timeout_o !== e.e_to) begin
            $display("[TB] FAIL vec%0d timeout_o: got %b want %b", n_vec, timeout_o, e.e_to);
            n_mis++;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, queue the expectation,
    // then check #1 after the rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge ACLK);
        reg_wr_i   = v.wr;
        reg_data_i = v.data;
        commit_i   = v.commit;
        sync_i     = v.sync;
        clr_i      = v.clr;
        exp_q.push_back(v);
        @(posedge ACLK);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [127:0] axi;
        logic [127:0] act;
        vec_t         zero_v;

        zero_v = mk(4'b0, 128'b0, 1'b0, 1'b0, 1'b0, 128'b0, 4'b0, 1'b0, 1'b0, 1'b0);

        // Outputs while held in reset.
        repeat (2) @(posedge ACLK);
        #1;
        exp_q.push_back(zero_v);
        checkOutput();
        @(negedge ACLK);
        ARESETN = 1'b1;

        // Single register write, commit, sync GAP cycles later.
        act = '0;
        axi = sl(1, 32'hA5);
        addVec(4'b0010, axi, 0, 0, 0, act, 4'b0010, 0, 0, 0);
        addVec(4'b0000, axi, 1, 0, 0, act, 4'b0010, 1, 0, 0);
        for (int i = 0; i < GAP - 1; i++) addVec(4'b0000, axi, 0, 0, 0, act, 4'b0010, 1, 0, 0);
        act = sl(1, 32'hA5);
        addVec(4'b0000, axi, 0, 1, 0, act, 4'b0000, 0, 1, 0);
        addVec(4'b0000, axi, 0, 0, 0, act, 4'b0000, 0, 0, 0);

        // Commit with nothing dirty is ignored, and so are bare syncs.
        for (int i = 0; i < 50; i++)
            addVec(4'b0000, axi, (i == 0 || i == 20), (i == 5 || i == 20 || i == 35), 0,
                   act, 4'b0000, 0, 0, 0);

        // Commit and sync in the same IDLE cycle only arm the load.
        axi = sl(1, 32'hA5) | sl(0, 32'h11);
        addVec(4'b0001, axi, 0, 0, 0, act, 4'b0001, 0, 0, 0);
        addVec(4'b0000, axi, 1, 1, 0, act, 4'b0001, 1, 0, 0);
        addVec(4'b0000, axi, 0, 0, 0, act, 4'b0001, 1, 0, 0);
        act = sl(1, 32'hA5) | sl(0, 32'h11);
        addVec(4'b0000, axi, 0, 1, 0, act, 4'b0000, 0, 1, 0);
        addVec(4'b0000, axi, 0, 0, 0, act, 4'b0000, 0, 0, 0);

        // Writes while pending join the load. A write coincident with sync
        // is loaded and stays dirty. A commit while pending is ignored.
        axi = sl(0, 32'h11) | sl(1, 32'hA5) | sl(2, 32'h55);
        addVec(4'b0100, axi, 0, 0, 0, act, 4'b0100, 0, 0, 0);
        addVec(4'b0000, axi, 1, 0, 0, act, 4'b0100, 1, 0, 0);
        axi = axi | sl(3, 32'h77);
        addVec(4'b1000, axi, 0, 0, 0, act, 4'b1100, 1, 0, 0);
        addVec(4'b0000, axi, 1, 0, 0, act, 4'b1100, 1, 0, 0);
        axi = sl(0, 32'h11) | sl(1, 32'hA5) | sl(2, 32'h1234) | sl(3, 32'h77);
        act = axi;
        addVec(4'b0100, axi, 0, 1, 0, act, 4'b0100, 0, 1, 0);
        addVec(4'b0000, axi, 0, 0, 0, act, 4'b0100, 0, 0, 0);

        // Non-dirty slices keep their value even when reg_data_i differs.
        axi = sl(0, 32'h99) | sl(1, 32'hA5) | sl(2, 32'hBEEF) | sl(3, 32'h77);
        addVec(4'b0100, axi, 0, 0, 0, act, 4'b0100, 0, 0, 0);
        addVec(4'b0000, axi, 1, 0, 0, act, 4'b0100, 1, 0, 0);
        act = sl(0, 32'h11) | sl(1, 32'hA5) | sl(2, 32'hBEEF) | sl(3, 32'h77);
        addVec(4'b0000, axi, 0, 1, 0, act, 4'b0000, 0, 1, 0);
        addVec(4'b0000, axi, 0, 0, 0, act, 4'b0000, 0, 0, 0);

`ifdef XNPC_SHADOW_TIMEOUT_EN
        // Forced load 16 edges after PENDING entry. A commit at the fifth
        // edge must not restart the count.
        axi = sl(0, 32'h99) | sl(1, 32'h5A) | sl(2, 32'hBEEF) | sl(3, 32'h77);
        addVec(4'b0010, axi, 0, 0, 0, act, 4'b0010, 0, 0, 0);
        addVec(4'b0000, axi, 1, 0, 0, act, 4'b0010, 1, 0, 0);
        for (int k = 1; k <= 15; k++) addVec(4'b0000, axi, (k == 5), 0, 0, act, 4'b0010, 1, 0, 0);
        act = sl(0, 32'h11) | sl(1, 32'h5A) | sl(2, 32'hBEEF) | sl(3, 32'h77);
        addVec(4'b0000, axi, 0, 0, 0, act, 4'b0000, 0, 1, 1);
        addVec(4'b0000, axi, 0, 0, 0, act, 4'b0000, 0, 0, 1);
        addVec(4'b0000, axi, 0, 0, 0, act, 4'b0000, 0, 0, 1);
        addVec(4'b0000, axi, 0, 0, 1, act, 4'b0000, 0, 0, 0);
        addVec(4'b0000, axi, 0, 0, 0, act, 4'b0000, 0, 0, 0);

        // A clear coincident with a new timeout leaves the flag set.
        axi = sl(0, 32'h99) | sl(1, 32'h5A) | sl(2, 32'hBEEF) | sl(3, 32'h33);
        addVec(4'b1000, axi, 0, 0, 0, act, 4'b1000, 0, 0, 0);
        addVec(4'b0000, axi, 1, 0, 0, act, 4'b1000, 1, 0, 0);
        for (int k = 1; k <= 15; k++) addVec(4'b0000, axi, 0, 0, 0, act, 4'b1000, 1, 0, 0);
        act = sl(0, 32'h11) | sl(1, 32'h5A) | sl(2, 32'hBEEF) | sl(3, 32'h33);
        addVec(4'b0000, axi, 0, 0, 1, act, 4'b0000, 0, 1, 1);
        addVec(4'b0000, axi, 0, 0, 0, act, 4'b0000, 0, 0, 1);
        addVec(4'b0000, axi, 0, 0, 1, act, 4'b0000, 0, 0, 0);

        // Re-arm a pending request for the reset sequence.
        addVec(4'b0001, axi, 0, 0, 0, act, 4'b0001, 0, 0, 0);
        addVec(4'b0000, axi, 1, 0, 0, act, 4'b0001, 1, 0, 0);
        addVec(4'b0000, axi, 0, 0, 0, act, 4'b0001, 1, 0, 0);
`else
        // Without the timeout, PENDING waits indefinitely and clr_i is inert.
        axi = sl(0, 32'h99) | sl(1, 32'h5A) | sl(2, 32'hBEEF) | sl(3, 32'h77);
        addVec(4'b0010, axi, 0, 0, 0, act, 4'b0010, 0, 0, 0);
        addVec(4'b0000, axi, 1, 0, 0, act, 4'b0010, 1, 0, 0);
        for (int i = 0; i < 1000; i++)
            addVec(4'b0000, axi, 0, 0, (i % 100 == 50), act, 4'b0010, 1, 0, 0);
`endif

        for (int i = 0; i < table_q.size(); i++) applyStimulus(table_q[i]);

        // Reset during PENDING: asynchronous clear, held three cycles.
        @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        exp_q.push_back(zero_v);
        checkOutput();
        for (int i = 0; i < 3; i++) begin
            @(posedge ACLK);
            #1;
            exp_q.push_back(zero_v);
            checkOutput();
        end
        @(negedge ACLK);
        ARESETN = 1'b1;

        // The discarded request must not load on the next sync.
        applyStimulus(mk(4'b0000, axi, 0, 1, 0, 128'b0, 4'b0000, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            applyStimulus(mk(4'b0000, axi, (i == 1), (i == 2), 0, 128'b0, 4'b0000, 0, 0, 0));

        if (exp_q.size() != 0) begin
            $display("[TB] FAIL scoreboard drain: got %0d left, want 0", exp_q.size());
            n_mis++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
